// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall unit: FSM state encoding,
// the default memory-wait timeout and the counter widths.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } hz_state_e;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WAIT_W          = 8;
  localparam int STATS_W         = 16;

endpackage

// File: rtl/hazard_stats_counter.sv
// Saturating statistics counter with synchronous reset and a parallel load
// (the load lets a counter be seeded, e.g. to exercise saturation).
module hazard_stats_counter
  import hazard_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [STATS_W-1:0] load_val,
  input  logic               inc,
  output logic [STATS_W-1:0] count
);

  logic [STATS_W-1:0] count_r;

  // Counter register: reset, load, or saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {STATS_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (inc && (count_r != {STATS_W{1'b1}})) begin
      count_r <= count_r + {{(STATS_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard unit: memory-wait FSM with timeout, branch flush and
// load-use stall. Optional statistics counters enabled by HAZARD_STATS_EN.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       RegA_D,
  input  logic [N-1:0]       RegB_D,
  input  logic [N-1:0]       Rd_E,
  input  logic               memtoreg_E,
  input  logic               regw_E,
  input  logic               branch_E,
  input  logic               mem_req_M,
  input  logic               mem_ready,
  output logic               stall_F,
  output logic               stall_D,
  output logic               stall_E,
  output logic               stall_M,
  output logic               flush_D,
  output logic               flush_E,
  output logic               mem_err,
  output logic [STATS_W-1:0] stall_cnt,
  output logic [STATS_W-1:0] flush_cnt
);

  hz_state_e         state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_wait_s;
  logic              load_use_s;

  // Memory-wait FSM; the error is taken when the incremented wait count
  // would reach TIMEOUT, but a same-cycle mem_ready always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_req_M && !mem_ready) begin
            state_r    <= MEM_WAIT;
            wait_cnt_r <= {WAIT_W{1'b0}};
          end else begin
            state_r    <= IDLE;
            wait_cnt_r <= wait_cnt_r;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_r <= IDLE;
          end else if (wait_cnt_r == WAIT_W'(TIMEOUT - 1)) begin
            state_r <= MEM_ERR;
          end else begin
            state_r <= MEM_WAIT;
          end
          if (wait_cnt_r != {WAIT_W{1'b1}}) begin
            wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        MEM_ERR: begin
          state_r    <= MEM_ERR;
          wait_cnt_r <= wait_cnt_r;
        end
        default: begin
          state_r    <= IDLE;
          wait_cnt_r <= {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // The stall drops in the very cycle memory completes, so the M stage can advance.
  assign mem_wait_s = (state_r == MEM_ERR) ||
                      (((state_r == MEM_WAIT) || mem_req_M) && !mem_ready);
  assign load_use_s = memtoreg_E && regw_E && (Rd_E != {N{1'b0}}) &&
                      ((Rd_E == RegA_D) || (Rd_E == RegB_D));
  assign mem_err    = (state_r == MEM_ERR);

  // Output decode with priority memory wait > branch > load-use.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if (mem_wait_s) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
    end else if (branch_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (load_use_s) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end else begin
      stall_F = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  hazard_stats_counter u_stall_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ({STATS_W{1'b0}}),
    .inc      (stall_F),
    .count    (stall_cnt)
  );

  hazard_stats_counter u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ({STATS_W{1'b0}}),
    .inc      (flush_E),
    .count    (flush_cnt)
  );
`else
  assign stall_cnt = {STATS_W{1'b0}};
  assign flush_cnt = {STATS_W{1'b0}};
`endif

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter N, default 4, register-ID width.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of memory-wait cycles before an error is flagged; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-005 SHALL have ports RegA_D and RegB_D, input, N each, the source register IDs in decode.
REQ-006 SHALL have ports Rd_E, memtoreg_E and regw_E, input, N/1/1, the destination ID, load flag and write-enable in execute.
REQ-007 SHALL have port branch_E, input, 1, a taken branch resolved in execute.
REQ-008 SHALL have ports mem_req_M and mem_ready, input, 1 each: a memory op is in M, and the memory has completed.
REQ-009 SHALL have ports stall_F, stall_D, stall_E and stall_M, output, 1 each, the pipeline-register hold enables.
REQ-010 SHALL have ports flush_D and flush_E, output, 1 each, the bubble-insert controls.
REQ-011 SHALL have port mem_err, output, 1, a sticky memory-timeout flag.
REQ-012 SHALL have ports stall_cnt and flush_cnt, output, 16 each, the statistics counters (see Configuration).

Function
REQ-013 SHALL implement an FSM with states IDLE, MEM_WAIT and MEM_ERR.
REQ-014 SHALL transition IDLE->MEM_WAIT when mem_req_M=1 and mem_ready=0.
REQ-015 SHALL transition MEM_WAIT->IDLE on the cycle mem_ready=1.
REQ-016 SHALL transition MEM_WAIT->MEM_ERR when the wait counter reaches TIMEOUT without mem_ready; MEM_ERR is left only by rst.
REQ-017 SHALL make outputs combinational from state and current inputs, with no added latency; the FSM and counters are registered.
REQ-018 SHALL stall all stages in memory wait: when the state is MEM_WAIT or MEM_ERR, or when in IDLE with mem_req_M=1 and mem_ready=0, stall_F/D/E/M=1 and flush_D/E=0.
REQ-019 SHALL detect a load-use hazard as memtoreg_E and regw_E and Rd_E!=0 and (Rd_E==RegA_D or Rd_E==RegB_D).
REQ-020 SHALL respond to a load-use hazard, absent memory wait and branch, with stall_F=stall_D=1 and flush_E=1 for exactly the detecting cycle.
REQ-021 SHALL respond to branch_E=1, absent memory wait, with flush_D=flush_E=1 and all stalls 0.
REQ-022 SHALL apply the priority memory wait > branch > load-use when events coincide.
REQ-023 SHALL clear the 8-bit wait counter on entry to MEM_WAIT and increment it each cycle in MEM_WAIT, with no wrap-around.
REQ-024 SHALL set mem_err=1 whenever the state is MEM_ERR.
REQ-025 SHALL, when mem_ready=1 arrives on the same cycle the counter reaches TIMEOUT, take mem_ready and go to IDLE with no error.
REQ-026 SHALL, when mem_req_M=1 and mem_ready=1 are both high in IDLE, produce no stall.

Reset
REQ-027 SHALL on rst=1 set state=IDLE, wait counter=0, mem_err=0, stall_cnt=0 and flush_cnt=0; combinational outputs follow from IDLE.
REQ-028 SHALL let rst in MEM_WAIT or MEM_ERR abort to IDLE in the next cycle, with outputs otherwise driven per REQ-018..021.

Configuration
REQ-029 SHALL, with HAZARD_STATS_EN defined, make stall_cnt count cycles with stall_F=1 and flush_cnt count cycles with flush_E=1; both are 16-bit and saturate at 0xFFFF.
REQ-030 SHALL, with HAZARD_STATS_EN undefined, tie stall_cnt and flush_cnt to 0 and synthesize no counter logic.

Structure
REQ-031 SHALL place the FSM state enum, the TIMEOUT default and the counter width constant in shared package hazard_pkg.
REQ-032 SHALL implement the saturating counter as sub-module hazard_stats_counter, instantiated twice.

Verification
REQ-033 SHALL cover load-use: memtoreg_E=1, regw_E=1, Rd_E=3, RegB_D=3 -> stall_F=stall_D=flush_E=1 for one cycle; Rd_E=0 -> no stall.
REQ-034 SHALL cover memory wait: mem_req_M=1, mem_ready low 5 cycles -> all four stalls high for 5 cycles, released the cycle mem_ready=1.
REQ-035 SHALL cover timeout: TIMEOUT=4, mem_ready never high -> mem_err=1 after 4 wait cycles, held until rst, then IDLE with all outputs 0.
REQ-036 SHALL cover priority: branch_E=1 plus a load-use hazard -> flush_D=flush_E=1, stall_F=0; the same with a memory wait -> stalls only.
REQ-037 SHALL cover statistics: with HAZARD_STATS_EN, 3 load-use events -> stall_cnt=3, flush_cnt=3; preloaded 0xFFFF -> stays 0xFFFF.
REQ-038 SHALL cover mid-wait reset: rst during MEM_WAIT -> next cycle state IDLE, counters 0.
